// File: rtl/irq_stim_pkg.sv
// irq_stim_pkg: shared types for the interrupt stimulus generator.
// Source modes, per-source config bundle and the LFSR step.
package irq_stim_pkg;

  localparam int CFG_CNT_W = 32;
  localparam int CFG_ID_W  = 32;

  // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_RANDOM   = 2'd3
  } irq_mode_e;

  typedef struct packed {
    irq_mode_e              mode;
    logic [CFG_CNT_W-1:0]   period;
    logic [CFG_ID_W-1:0]    id;
    logic                   sec;
  } irq_src_cfg_t;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return s[0] ? ((s >> 1) ^ LFSR_POLY)
                : (s >> 1);
  endfunction

endpackage

// File: rtl/irq_stim_chan.sv
// irq_stim_chan: one interrupt source.
// Holds mode/period/ID, counts down, fires and tracks pending.
module irq_stim_chan
  import irq_stim_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int ID_WIDTH  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 we_i,
  input  irq_src_cfg_t         cfg_i,
  input  logic [CNT_WIDTH-1:0] rnd_i,
  input  logic                 clr_i,
  output logic                 fire_o,
  output logic                 overrun_o,
  output logic                 pending_o,
  output logic [ID_WIDTH-1:0]  id_o,
  output logic                 sec_o
);

  irq_mode_e            mode_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] wr_period;
  logic                 unused_cfg;

  assign wr_period  = cfg_i.period[CNT_WIDTH-1:0];
  assign unused_cfg = ^{cfg_i.period, cfg_i.id};

  assign fire_o = enable_i
               && (mode_q != MODE_OFF)
               && (cnt_q == '0);

  // a fire on a source being cleared is not an overrun
  assign overrun_o = fire_o && pending_o && !clr_i;

  // config write, countdown and reload on fire
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q   <= MODE_OFF;
      cnt_q    <= '0;
      period_q <= '0;
      id_o     <= '0;
      sec_o    <= 1'b0;
    end else if (we_i) begin
      mode_q   <= cfg_i.mode;
      period_q <= wr_period;
      id_o     <= cfg_i.id[ID_WIDTH-1:0];
      sec_o    <= cfg_i.sec;
      if (cfg_i.mode == MODE_RANDOM)
        cnt_q <= (rnd_i & wr_period)
               | CNT_WIDTH'(1);
      else
        cnt_q <= wr_period;
    end else if (fire_o) begin
      unique case (mode_q)
        MODE_ONESHOT:  mode_q <= MODE_OFF;
        MODE_PERIODIC: cnt_q  <= period_q;
        MODE_RANDOM:   cnt_q  <= (rnd_i & period_q)
                               | CNT_WIDTH'(1);
        default: ;
      endcase
    end else if (enable_i && mode_q != MODE_OFF) begin
      cnt_q <= cnt_q - CNT_WIDTH'(1);
    end
  end

  // pending: set by fire, cleared by accept; fire wins a tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      pending_o <= 1'b0;
    else if (fire_o)
      pending_o <= 1'b1;
    else if (clr_i)
      pending_o <= 1'b0;
  end

endmodule

// File: rtl/irq_stim_gen.sv
// irq_stim_gen: N-source interrupt stimulus for the core bench.
// LFSR, fixed-priority grant latch, ack handshake, statistics.
module irq_stim_gen
  import irq_stim_pkg::*;
#(
  parameter int          N_SRC     = 4,
  parameter int          ID_WIDTH  = 5,
  parameter int          CNT_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 cfg_we_i,
  input  logic [SRC_W-1:0]     cfg_src_i,
  input  logic [1:0]           cfg_mode_i,
  input  logic [CNT_WIDTH-1:0] cfg_period_i,
  input  logic [ID_WIDTH-1:0]  cfg_id_i,
  input  logic                 cfg_sec_i,
  output logic                 irq_o,
  output logic [ID_WIDTH-1:0]  irq_id_o,
  output logic                 irq_sec_o,
  input  logic                 irq_ack_i,
  input  logic [ID_WIDTH-1:0]  irq_ack_id_i,
  output logic [N_SRC-1:0]     pending_o,
  output logic [31:0]          event_cnt_o,
  output logic [31:0]          overrun_cnt_o,
  output logic [31:0]          spurious_cnt_o
);

  logic [15:0]             lfsr_q;
  logic [CNT_WIDTH+15:0]   lfsr_ext;
  logic [CNT_WIDTH-1:0]    rnd;
  irq_src_cfg_t            cfg;
  logic [N_SRC-1:0]        fire;
  logic [N_SRC-1:0]        ovr;
  logic [N_SRC-1:0]        clr;
  logic [ID_WIDTH-1:0]     src_id  [N_SRC];
  logic                    src_sec [N_SRC];
  logic [SRC_W-1:0]        gnt_q;
  logic [SRC_W-1:0]        pick;
  logic                    accept;
  logic                    spurious;
  logic [31:0]             n_fire;
  logic [31:0]             n_ovr;

  assign lfsr_ext = {{CNT_WIDTH{1'b0}}, lfsr_q};
  assign rnd      = lfsr_ext[CNT_WIDTH-1:0];

  assign cfg = '{
    mode:   irq_mode_e'(cfg_mode_i),
    period: CFG_CNT_W'(cfg_period_i),
    id:     CFG_ID_W'(cfg_id_i),
    sec:    cfg_sec_i
  };

  assign accept   = irq_ack_i && irq_o
                 && (irq_ack_id_i == irq_id_o);
  assign spurious = irq_ack_i && !accept;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    logic we;
    assign we     = cfg_we_i && (cfg_src_i == SRC_W'(g));
    assign clr[g] = accept && (gnt_q == SRC_W'(g));

    irq_stim_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .ID_WIDTH  (ID_WIDTH)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .enable_i  (enable_i),
      .we_i      (we),
      .cfg_i     (cfg),
      .rnd_i     (rnd),
      .clr_i     (clr[g]),
      .fire_o    (fire[g]),
      .overrun_o (ovr[g]),
      .pending_o (pending_o[g]),
      .id_o      (src_id[g]),
      .sec_o     (src_sec[g])
    );
  end

  // LFSR free-runs, independent of enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      lfsr_q <= LFSR_SEED;
    else
      lfsr_q <= lfsr_step(lfsr_q);
  end

  // lowest-index pending source and per-cycle event tallies
  always_comb begin
    pick   = '0;
    n_fire = '0;
    n_ovr  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending_o[i])
        pick = SRC_W'(i);
    end
    for (int i = 0; i < N_SRC; i++) begin
      n_fire = n_fire + 32'(fire[i]);
      n_ovr  = n_ovr + 32'(ovr[i]);
    end
  end

  // grant latch: request holds until accepted, then drops a cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_o     <= 1'b0;
      irq_id_o  <= '0;
      irq_sec_o <= 1'b0;
      gnt_q     <= '0;
    end else if (accept) begin
      irq_o <= 1'b0;
    end else if (!irq_o && |pending_o) begin
      irq_o     <= 1'b1;
      gnt_q     <= pick;
      irq_id_o  <= src_id[pick];
      irq_sec_o <= src_sec[pick];
    end
  end

  // statistics, free-wrapping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      event_cnt_o    <= '0;
      overrun_cnt_o  <= '0;
      spurious_cnt_o <= '0;
    end else begin
      event_cnt_o    <= event_cnt_o + n_fire;
      overrun_cnt_o  <= overrun_cnt_o + n_ovr;
      spurious_cnt_o <= spurious_cnt_o
                      + 32'(spurious);
    end
  end

endmodule
